// File: rtl/cb_vm_addr_seq.sv
// cb_vm_addr_seq
//   Streams the CB word addresses of one group over a valid/ready interface.
//   The group base address and group index are latched on an accepted start.
//   The group length is {group_cnt[ROW_LEN-1:1],3'b000} + 8 + group_cnt[0],
//   so consecutive groups tile the CB without gaps. Addresses wrap modulo 2^CB_AW.
//
// Ports
//   clk           system clock, rising edge
//   sys_rst_n     asynchronous active-low reset
//   start         1-cycle request, sampled only in IDLE
//   abort         synchronous cancel of the current sequence
//   CB_base_addr  group base address, latched on accepted start
//   group_cnt     group index, latched on accepted start
//   addr_ready    consumer accepts the current beat
//   addr_valid    addr_out is valid
//   addr_out      current CB word address
//   addr_last     final beat of the group, qualified by addr_valid
//   busy          sequence in progress (CALC, BURST or DONE)
//   done          1-cycle pulse after the last beat is accepted
//   addr_ovf      sticky address-overflow flag
//
// Configuration
//   CB_SEQ_OVF_CHK_EN : when defined, a group whose end address base+len-1
//   carries out of CB_AW bits sets addr_ovf. The flag clears on reset or on
//   an accepted start. When undefined, addr_ovf is tied to 0.

module cb_vm_addr_seq #(
    parameter int CB_AW   = 19,
    parameter int ROW_LEN = 10
) (
    input  logic               clk,
    input  logic               sys_rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [CB_AW-1:0]   CB_base_addr,
    input  logic [ROW_LEN-1:0] group_cnt,
    input  logic               addr_ready,
    output logic               addr_valid,
    output logic [CB_AW-1:0]   addr_out,
    output logic               addr_last,
    output logic               busy,
    output logic               done,
    output logic               addr_ovf
);

    typedef enum logic [1:0] {IDLE, CALC, BURST, DONE} state_t;

    state_t             state, state_d;
    logic [CB_AW-1:0]   base_q, base_d;
    logic [ROW_LEN-1:0] gcnt_q, gcnt_d;
    logic [CB_AW-1:0]   idx, idx_d, idx_inc;
    logic [CB_AW-1:0]   last_idx, last_idx_d;
    logic [CB_AW-1:0]   len_calc;
    logic [CB_AW-1:0]   out_d;
    logic               valid_d, last_d, busy_d, done_d;
    logic               start_acc, xfer;

    always_comb begin
        len_calc = CB_AW'({gcnt_q[ROW_LEN-1:1], 3'b000}) + CB_AW'(8) + CB_AW'(gcnt_q[0]);
    end

    assign start_acc = (state == IDLE) && start && !abort;
    assign xfer      = addr_valid && addr_ready;
    assign idx_inc   = idx + CB_AW'(1);

    // All outputs are registered: the next-state logic computes their next
    // values, so addr_ready never reaches addr_valid/addr_out combinationally.
    always_comb begin
        state_d    = state;
        base_d     = base_q;
        gcnt_d     = gcnt_q;
        idx_d      = idx;
        last_idx_d = last_idx;
        valid_d    = addr_valid;
        out_d      = addr_out;
        last_d     = addr_last;
        busy_d     = busy;
        done_d     = 1'b0;

        case (state)
            IDLE: begin
                if (start_acc) begin
                    base_d  = CB_base_addr;
                    gcnt_d  = group_cnt;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                last_idx_d = len_calc - CB_AW'(1);
                idx_d      = '0;
                valid_d    = 1'b1;
                out_d      = base_q;
                last_d     = 1'b0;  // len >= 8, so beat 0 is never the last
                state_d    = BURST;
            end
            BURST: begin
                if (xfer) begin
                    if (addr_last) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d  = idx_inc;
                        out_d  = base_q + idx_inc;
                        last_d = (idx_inc == last_idx);
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides every active state, including a final transfer:
        // the beat is consumed but no done pulse is produced.
        if (abort && (state != IDLE)) begin
            state_d = IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            base_q     <= '0;
            gcnt_q     <= '0;
            idx        <= '0;
            last_idx   <= '0;
            addr_valid <= 1'b0;
            addr_out   <= '0;
            addr_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            base_q     <= base_d;
            gcnt_q     <= gcnt_d;
            idx        <= idx_d;
            last_idx   <= last_idx_d;
            addr_valid <= valid_d;
            addr_out   <= out_d;
            addr_last  <= last_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

`ifdef CB_SEQ_OVF_CHK_EN
    logic [CB_AW:0] end_addr;

    always_comb begin
        end_addr = {1'b0, base_q} + {1'b0, len_calc} - (CB_AW+1)'(1);
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            addr_ovf <= 1'b0;
        end else if (start_acc) begin
            addr_ovf <= 1'b0;
        end else if ((state == CALC) && end_addr[CB_AW]) begin
            addr_ovf <= 1'b1;
        end
    end
`else
    assign addr_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cb_vm_addr_seq.sv
module tb_cb_vm_addr_seq;

    localparam int AW = 19;
    localparam int RL = 10;

    logic          clk = 1'b0;
    logic          sys_rst_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] CB_base_addr;
    logic [RL-1:0] group_cnt;
    logic          addr_ready;
    logic          addr_valid;
    logic [AW-1:0] addr_out;
    logic          addr_last;
    logic          busy;
    logic          done;
    logic          addr_ovf;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] exp_addr[$];
    logic          exp_last[$];

    cb_vm_addr_seq #(.CB_AW(AW), .ROW_LEN(RL)) dut (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .start        (start),
        .abort        (abort),
        .CB_base_addr (CB_base_addr),
        .group_cnt    (group_cnt),
        .addr_ready   (addr_ready),
        .addr_valid   (addr_valid),
        .addr_out     (addr_out),
        .addr_last    (addr_last),
        .busy         (busy),
        .done         (done),
        .addr_ovf     (addr_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the expected beats of one group onto the scoreboard.
    task automatic push_group(input logic [AW-1:0] b, input logic [RL-1:0] g);
        int len;
        len = (int'(g) >> 1) * 8 + 8 + int'(g[0]);
        for (int i = 0; i < len; i++) begin
            exp_addr.push_back(b + AW'(i));
            exp_last.push_back(i == len - 1);
        end
    endtask

    // Drive start for one cycle in the current cycle T; returns in T+1.
    task automatic start_group(input logic [AW-1:0] b, input logic [RL-1:0] g);
        CB_base_addr = b;
        group_cnt    = g;
        start        = 1'b1;
        push_group(b, g);
        tick();
        start        = 1'b0;
        CB_base_addr = ~b;   // later changes must not affect the group
        group_cnt    = ~g;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; start = 1'b0; abort = 1'b0; addr_ready = 1'b0;
        CB_base_addr = '0; group_cnt = '0;
        tick(); tick();
        checks++;
        if ({addr_valid, addr_out, addr_last, busy, done, addr_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs valid=%0b addr=%0d last=%0b busy=%0b done=%0b ovf=%0b, expected all 0",
                     addr_valid, addr_out, addr_last, busy, done, addr_ovf);
        end
        sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int beats; bit seen; logic [AW-1:0] ea; logic el;
        beats = 0; seen = 0; addr_ready = 1'b1; abort = 1'b0;
        start_group(19'd2, 10'd0);
        checks++;
        if (busy !== 1'b1 || addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_calc busy=%0b valid=%0b, expected busy=1 valid=0", busy, addr_valid);
        end
        for (int n = 2; n < 40; n++) begin
            tick();
            if (addr_valid && addr_ready) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++; $display("FAIL basic_beat unexpected beat addr=%0d", addr_out);
                end else begin
                    ea = exp_addr.pop_front(); el = exp_last.pop_front();
                    if (addr_out !== ea || addr_last !== el || (beats == 0 && n != 2)) begin
                        errors++;
                        $display("FAIL basic_beat addr=%0d last=%0b cycle=%0d, expected addr=%0d last=%0b",
                                 addr_out, addr_last, n, ea, el);
                    end
                end
                beats++;
            end
            if (done) begin
                seen = 1; checks++;
                if (n != 10 || exp_addr.size() != 0 || addr_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_done cycle=%0d left=%0d valid=%0b busy=%0b, expected cycle=10 left=0 valid=0 busy=1",
                             n, exp_addr.size(), addr_valid, busy);
                end
                break;
            end
        end
        if (!seen) begin checks++; errors++; $display("FAIL basic_timeout done not seen, expected done at T+10"); end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || addr_ovf !== 1'b0) begin
            errors++; $display("FAIL basic_idle busy=%0b done=%0b ovf=%0b, expected 0 0 0", busy, done, addr_ovf);
        end
    endtask

    task automatic test_group3();
        bit seen; logic [AW-1:0] ea; logic el;
        seen = 0; addr_ready = 1'b1; exp_addr.delete(); exp_last.delete();
        start_group(19'd100, 10'd3);
        for (int n = 1; n < 60; n++) begin
            if (n > 1) tick();
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL group3_busy busy=%0b cycle=%0d, expected 1", busy, n); end
            if (addr_valid && addr_ready) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++; $display("FAIL group3_beat unexpected beat addr=%0d", addr_out);
                end else begin
                    ea = exp_addr.pop_front(); el = exp_last.pop_front();
                    if (addr_out !== ea || addr_last !== el) begin
                        errors++;
                        $display("FAIL group3_beat addr=%0d last=%0b, expected addr=%0d last=%0b", addr_out, addr_last, ea, el);
                    end
                end
            end
            if (done) begin
                seen = 1; checks++;
                if (n != 19 || exp_addr.size() != 0) begin
                    errors++; $display("FAIL group3_done cycle=%0d left=%0d, expected cycle=19 left=0", n, exp_addr.size());
                end
                break;
            end
        end
        if (!seen) begin checks++; errors++; $display("FAIL group3_timeout done not seen, expected done at T+19"); end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL group3_busy_end busy=%0b at T+20, expected 0", busy); end
    endtask

    task automatic test_stall();
        int beats; int stall; bit seen; logic [AW-1:0] ea; logic el;
        beats = 0; stall = 3; seen = 0; addr_ready = 1'b1; exp_addr.delete(); exp_last.delete();
        start_group(19'd100, 10'd3);
        for (int n = 2; n < 60; n++) begin
            tick();
            if (beats == 5 && stall > 0) begin
                addr_ready = 1'b0; stall--;
                checks++;
                if (addr_valid !== 1'b1 || addr_out !== 19'd105 || addr_last !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold valid=%0b addr=%0d last=%0b, expected valid=1 addr=105 last=0",
                             addr_valid, addr_out, addr_last);
                end
            end else begin
                addr_ready = 1'b1;
            end
            if (addr_valid && addr_ready) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++; $display("FAIL stall_beat unexpected beat addr=%0d", addr_out);
                end else begin
                    ea = exp_addr.pop_front(); el = exp_last.pop_front();
                    if (addr_out !== ea || addr_last !== el) begin
                        errors++;
                        $display("FAIL stall_beat addr=%0d last=%0b, expected addr=%0d last=%0b", addr_out, addr_last, ea, el);
                    end
                end
                beats++;
            end
            if (done) begin
                seen = 1; checks++;
                if (n != 22 || beats != 17) begin
                    errors++; $display("FAIL stall_done cycle=%0d beats=%0d, expected cycle=22 beats=17", n, beats);
                end
                break;
            end
        end
        if (!seen) begin checks++; errors++; $display("FAIL stall_timeout done not seen, expected done at T+22"); end
        addr_ready = 1'b1;
        tick();
    endtask

    task automatic test_abort();
        int beats; bit aborted; bit bad; logic [AW-1:0] ea; logic el;
        beats = 0; aborted = 0; bad = 0; addr_ready = 1'b1; exp_addr.delete(); exp_last.delete();
        start_group(19'd100, 10'd3);
        for (int n = 2; n < 40; n++) begin
            tick();
            start = (beats == 2);
            abort = (beats == 4);
            if (addr_valid && addr_ready) begin
                checks++;
                ea = exp_addr.pop_front(); el = exp_last.pop_front();
                if (addr_out !== ea || addr_last !== el) begin
                    errors++;
                    $display("FAIL abort_beat addr=%0d last=%0b, expected addr=%0d last=%0b", addr_out, addr_last, ea, el);
                end
                beats++;
            end
            if (abort) begin
                aborted = 1;
                tick();
                abort = 1'b0;
                checks++;
                if (addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_drop valid=%0b busy=%0b done=%0b, expected 0 0 0", addr_valid, busy, done);
                end
                break;
            end
        end
        if (!aborted) begin checks++; errors++; $display("FAIL abort_timeout idx 4 never reached, expected beat 4"); end
        exp_addr.delete(); exp_last.delete();
        for (int n = 0; n < 25; n++) begin
            tick();
            if (addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL abort_quiet activity after abort, expected idle"); end
        // start and abort together in IDLE: start is dropped
        CB_base_addr = 19'd7; group_cnt = 10'd0;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || addr_valid !== 1'b0) begin
            errors++; $display("FAIL abort_start_idle busy=%0b valid=%0b, expected 0 0", busy, addr_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit seen; logic [AW-1:0] ea; logic el;
        seen = 0; addr_ready = 1'b1; exp_addr.delete(); exp_last.delete();
        start_group(19'd50, 10'd0);
        for (int n = 2; n < 40; n++) begin
            tick();
            if (addr_valid && addr_ready) begin
                checks++;
                ea = exp_addr.pop_front(); el = exp_last.pop_front();
                if (addr_out !== ea || addr_last !== el) begin
                    errors++;
                    $display("FAIL b2b_beat addr=%0d last=%0b, expected addr=%0d last=%0b", addr_out, addr_last, ea, el);
                end
            end
            if (done) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL b2b_first_done done not seen, expected done"); end
        // start in the DONE cycle is ignored
        CB_base_addr = 19'd999; group_cnt = 10'd5; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_ignore busy=%0b, expected 0", busy); end
        // first cycle after DONE accepts the next start
        start_group(19'd200, 10'd0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%0b, expected 1", busy); end
        seen = 0;
        for (int n = 2; n < 40; n++) begin
            tick();
            if (addr_valid && addr_ready) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++; $display("FAIL b2b_beat2 unexpected beat addr=%0d", addr_out);
                end else begin
                    ea = exp_addr.pop_front(); el = exp_last.pop_front();
                    if (addr_out !== ea || addr_last !== el) begin
                        errors++;
                        $display("FAIL b2b_beat2 addr=%0d last=%0b, expected addr=%0d last=%0b", addr_out, addr_last, ea, el);
                    end
                end
            end
            if (done) begin
                seen = 1; checks++;
                if (n != 10 || exp_addr.size() != 0) begin
                    errors++; $display("FAIL b2b_done cycle=%0d left=%0d, expected cycle=10 left=0", n, exp_addr.size());
                end
                break;
            end
        end
        if (!seen) begin checks++; errors++; $display("FAIL b2b_timeout done not seen, expected done at T+10"); end
        tick();
    endtask

    task automatic test_reset_mid();
        int beats; bit hit; bit seen; logic [AW-1:0] ea; logic el;
        beats = 0; hit = 0; seen = 0; addr_ready = 1'b1; exp_addr.delete(); exp_last.delete();
        start_group(19'd100, 10'd3);
        for (int n = 2; n < 40; n++) begin
            tick();
            if (beats == 6) begin
                hit = 1;
                #2 sys_rst_n = 1'b0;
                #1;
                checks++;
                if ({addr_valid, addr_out, addr_last, busy, done} !== '0) begin
                    errors++;
                    $display("FAIL rstmid_clear valid=%0b addr=%0d last=%0b busy=%0b done=%0b, expected all 0",
                             addr_valid, addr_out, addr_last, busy, done);
                end
                break;
            end
            if (addr_valid && addr_ready) begin
                ea = exp_addr.pop_front(); el = exp_last.pop_front();
                beats++;
            end
        end
        if (!hit) begin checks++; errors++; $display("FAIL rstmid_timeout idx 6 never reached, expected beat 6"); end
        exp_addr.delete(); exp_last.delete();
        tick(); tick();
        sys_rst_n = 1'b1;
        tick();
        start_group(19'd0, 10'd1);
        for (int n = 2; n < 40; n++) begin
            tick();
            if (addr_valid && addr_ready) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++; $display("FAIL rstmid_beat unexpected beat addr=%0d", addr_out);
                end else begin
                    ea = exp_addr.pop_front(); el = exp_last.pop_front();
                    if (addr_out !== ea || addr_last !== el) begin
                        errors++;
                        $display("FAIL rstmid_beat addr=%0d last=%0b, expected addr=%0d last=%0b", addr_out, addr_last, ea, el);
                    end
                end
            end
            if (done) begin
                seen = 1; checks++;
                if (n != 11 || exp_addr.size() != 0) begin
                    errors++; $display("FAIL rstmid_done cycle=%0d left=%0d, expected cycle=11 left=0", n, exp_addr.size());
                end
                break;
            end
        end
        if (!seen) begin checks++; errors++; $display("FAIL rstmid_timeout done not seen, expected done at T+11"); end
        tick();
    endtask

    task automatic test_ovf();
        logic exp_ovf; bit seen; logic [AW-1:0] ea; logic el;
`ifdef CB_SEQ_OVF_CHK_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        seen = 0; addr_ready = 1'b1; exp_addr.delete(); exp_last.delete();
        start_group(19'h7FFFC, 10'd0);
        for (int n = 2; n < 40; n++) begin
            tick();
            if (n == 2) begin
                checks++;
                if (addr_ovf !== exp_ovf) begin
                    errors++; $display("FAIL ovf_set ovf=%0b, expected %0b", addr_ovf, exp_ovf);
                end
            end
            if (addr_valid && addr_ready) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++; $display("FAIL ovf_beat unexpected beat addr=%0d", addr_out);
                end else begin
                    ea = exp_addr.pop_front(); el = exp_last.pop_front();
                    if (addr_out !== ea || addr_last !== el) begin
                        errors++;
                        $display("FAIL ovf_beat addr=%0d last=%0b, expected addr=%0d last=%0b", addr_out, addr_last, ea, el);
                    end
                end
            end
            if (done) begin seen = 1; break; end
        end
        if (!seen) begin checks++; errors++; $display("FAIL ovf_timeout done not seen, expected done"); end
        tick(); tick(); tick();
        checks++;
        if (addr_ovf !== exp_ovf) begin errors++; $display("FAIL ovf_sticky ovf=%0b, expected %0b", addr_ovf, exp_ovf); end
        // end address exactly 2^19-1: no overflow, and the accepted start clears the flag
        exp_addr.delete(); exp_last.delete();
        start_group(19'h7FFF8, 10'd0);
        checks++;
        if (addr_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear ovf=%0b, expected 0", addr_ovf); end
        seen = 0;
        for (int n = 2; n < 40; n++) begin
            tick();
            if (addr_valid && addr_ready) begin
                checks++;
                ea = exp_addr.pop_front(); el = exp_last.pop_front();
                if (addr_out !== ea || addr_last !== el) begin
                    errors++;
                    $display("FAIL ovf_edge_beat addr=%0d last=%0b, expected addr=%0d last=%0b", addr_out, addr_last, ea, el);
                end
            end
            if (done) begin seen = 1; break; end
        end
        tick();
        checks++;
        if (!seen || addr_ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_edge done_seen=%0b ovf=%0b, expected done_seen=1 ovf=0", seen, addr_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_group3();
        test_stall();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_ovf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
